game_state_manager: RTL and testbench
=====================================

Name: game_state_manager

Overview:
- Consumes the per-pixel collision pulses produced by the collision detector and turns them into game-level state: score, lives, level, aliens remaining and the play/freeze state machine.
- Collisions are latched during a frame and committed once per frame on startOfFrame, so a multi-scanline overlap counts as exactly one event.
- Outputs drive the score/lives display, the alien matrix reload and object freeze.

Parameters:
LIVES_INIT, 3, lives loaded at game start (1..7)
ALIEN_COUNT, 24, aliens per level (1..63)
ALIEN_POINTS, 10, score added per committed alien kill
ROCKET_POINTS, 5, score added per committed rocket-vs-rocket collision
HIT_FREEZE_FRAMES, 60, frames frozen after player death (>=1)
LEVEL_PAUSE_FRAMES, 90, frames paused between levels (>=1)
SCORE_W, 16, score width; score saturates at 2^SCORE_W-1

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
startOfFrame  in  1  one-cycle pulse at frame start
startGame  in  1  level button; rising edge is used
alienHitPulse  in  1  player rocket hit alien
playerHitByAlienPulse  in  1  alien touched player
playerHitByRocketPulse  in  1  alien rocket hit player
rocketsCollisionPulse  in  1  rockets collided
aliensReachedBorder  in  1  aliens reached bottom border
gameState  out  3  IDLE=0, PLAYING=1, PLAYER_HIT=2, LEVEL_CLEAR=3, GAME_OVER=4
score  out  SCORE_W  current score
lives  out  3  remaining lives
level  out  4  current level, 1..15, saturating
aliensRemaining  out  6  aliens left in level
freezeGame  out  1  high whenever gameState != PLAYING
playerDiedPulse  out  1  one-cycle pulse on committed death
levelStartPulse  out  1  one-cycle pulse; alien matrix reloads

Behaviour:
- Reset, synchronous, active-high. State goes to IDLE. score=0, lives=LIVES_INIT, level=1, aliensRemaining=ALIEN_COUNT, freezeGame=1, all pulses=0, latches cleared, frame counter=0, startGame edge register=0.
- Event latches: alienL, rocketL, playerL (OR of both player-hit pulses) and borderL.
  - A latch sets on any cycle its input is high.
  - On the startOfFrame cycle all latches are read, then cleared.
  - An input pulse on that same cycle is kept for the next frame: set wins over clear.
- Commit happens on the startOfFrame cycle, in PLAYING only. All outputs are registered and take effect on the next cycle (latency 1). Priority order:
  1. borderL: go to GAME_OVER; no score update.
  2. playerL: pulse playerDiedPulse.
     - If lives==1: lives=0, go to GAME_OVER.
     - Otherwise: lives-1, go to PLAYER_HIT, frame counter=0.
  3. alienL and rocketL are scored in the same commit as a playerL death, but not with borderL. Add ALIEN_POINTS if alienL and ROCKET_POINTS if rocketL. The add saturates.
  4. alienL also decrements aliensRemaining, floored at 0. If the result is 0 and no death was committed, go to LEVEL_CLEAR with frame counter=0.
- In every state other than PLAYING, latches are cleared at startOfFrame and never committed.
- PLAYER_HIT: the frame counter increments on each startOfFrame. When it reaches HIT_FREEZE_FRAMES:
  - go to LEVEL_CLEAR (counter=0) if aliensRemaining==0;
  - otherwise go to PLAYING.
- LEVEL_CLEAR: the frame counter increments on each startOfFrame. When it reaches LEVEL_PAUSE_FRAMES:
  - level+1 (saturating at 15), aliensRemaining=ALIEN_COUNT, pulse levelStartPulse, go to PLAYING.
- IDLE or GAME_OVER, on a startGame rising edge (registered edge detect):
  - score=0, lives=LIVES_INIT, level=1, aliensRemaining=ALIEN_COUNT;
  - pulse levelStartPulse, go to PLAYING.
  - startGame is ignored in other states.
- The frame counter is wide enough for max(HIT_FREEZE_FRAMES, LEVEL_PAUSE_FRAMES) and never wraps.
- Reset asserted mid-game, on any cycle: the next state is IDLE with reset values; pending latches are discarded.

Test Plan:
- Reset, then a startGame rise: next cycle gameState=1, lives=3, score=0, aliensRemaining=24, one-cycle levelStartPulse.
- In PLAYING, 8 alienHitPulse pulses in one frame, then startOfFrame: score=10, aliensRemaining=23. An alienHitPulse coinciding with startOfFrame is committed at the next startOfFrame: score=20.
- playerHitByRocketPulse and alienHitPulse in the same frame: lives=2, score=10, gameState=2, playerDiedPulse for one cycle. After 60 startOfFrame pulses: gameState=1.
- 24 committed kills: gameState=3. After 90 frames: level=2, aliensRemaining=24, levelStartPulse, gameState=1.
- aliensReachedBorder together with alienHitPulse: gameState=4, score unchanged. A third death with lives=1: lives=0, gameState=4. A startGame rise then restarts the game with score=0.
- score preloaded near 65535 via kills, plus rocketsCollisionPulse: score saturates at 65535. Reset asserted mid-PLAYER_HIT: next cycle all reset values.

Source files
------------

// File: rtl/game_state_manager.sv
// Game-level bookkeeping: latches per-pixel collision pulses for one frame and commits them at frame start.
// Owns score, lives, level, alien count and the play/freeze state machine.
module game_state_manager #(
  parameter int LIVES_INIT         = 3,
  parameter int ALIEN_COUNT        = 24,
  parameter int ALIEN_POINTS       = 10,
  parameter int ROCKET_POINTS      = 5,
  parameter int HIT_FREEZE_FRAMES  = 60,
  parameter int LEVEL_PAUSE_FRAMES = 90,
  parameter int SCORE_W            = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               startGame,
  input  logic               alienHitPulse,
  input  logic               playerHitByAlienPulse,
  input  logic               playerHitByRocketPulse,
  input  logic               rocketsCollisionPulse,
  input  logic               aliensReachedBorder,
  output logic [2:0]         gameState,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic [3:0]         level,
  output logic [5:0]         aliensRemaining,
  output logic               freezeGame,
  output logic               playerDiedPulse,
  output logic               levelStartPulse
);

  localparam int MAX_FRAMES = (HIT_FREEZE_FRAMES > LEVEL_PAUSE_FRAMES) ?
                              HIT_FREEZE_FRAMES : LEVEL_PAUSE_FRAMES;
  localparam int CNT_W = $clog2(MAX_FRAMES + 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PLAYING     = 3'd1,
    PLAYER_HIT  = 3'd2,
    LEVEL_CLEAR = 3'd3,
    GAME_OVER   = 3'd4
  } state_t;

  state_t             state;
  logic               alienL, rocketL, playerL, borderL;
  logic               startGameD;
  logic [CNT_W-1:0]   frameCnt;
  logic [CNT_W-1:0]   frameCntInc;
  logic               playerHit;
  logic               startRise;
  logic [SCORE_W:0]   scoreSum;
  logic [SCORE_W-1:0] scoreSat;
  logic [5:0]         aliensAfter;

  assign gameState   = state;
  assign playerHit   = playerHitByAlienPulse | playerHitByRocketPulse;
  assign startRise   = startGame & ~startGameD;
  assign frameCntInc = frameCnt + 1'b1;

  // One extra sum bit catches overflow so the score pins at all-ones instead of wrapping.
  always_comb begin
    scoreSum = {1'b0, score};
    if (alienL)  scoreSum = scoreSum + (SCORE_W+1)'(ALIEN_POINTS);
    if (rocketL) scoreSum = scoreSum + (SCORE_W+1)'(ROCKET_POINTS);
    scoreSat    = scoreSum[SCORE_W] ? '1 : scoreSum[SCORE_W-1:0];
    aliensAfter = (aliensRemaining == 6'd0) ? 6'd0 : aliensRemaining - 6'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      score           <= '0;
      lives           <= 3'(LIVES_INIT);
      level           <= 4'd1;
      aliensRemaining <= 6'(ALIEN_COUNT);
      freezeGame      <= 1'b1;
      playerDiedPulse <= 1'b0;
      levelStartPulse <= 1'b0;
      alienL          <= 1'b0;
      rocketL         <= 1'b0;
      playerL         <= 1'b0;
      borderL         <= 1'b0;
      frameCnt        <= '0;
      startGameD      <= 1'b0;
    end else begin
      playerDiedPulse <= 1'b0;
      levelStartPulse <= 1'b0;
      startGameD      <= startGame;

      // NOTE: at frame start the old latch value is consumed and replaced by the live input, so a pulse landing on that cycle survives into the next frame.
      if (startOfFrame) begin
        alienL  <= alienHitPulse;
        rocketL <= rocketsCollisionPulse;
        playerL <= playerHit;
        borderL <= aliensReachedBorder;
      end else begin
        alienL  <= alienL  | alienHitPulse;
        rocketL <= rocketL | rocketsCollisionPulse;
        playerL <= playerL | playerHit;
        borderL <= borderL | aliensReachedBorder;
      end

      case (state)
        IDLE, GAME_OVER: begin
          if (startRise) begin
            score           <= '0;
            lives           <= 3'(LIVES_INIT);
            level           <= 4'd1;
            aliensRemaining <= 6'(ALIEN_COUNT);
            levelStartPulse <= 1'b1;
            freezeGame      <= 1'b0;
            state           <= PLAYING;
          end
        end

        PLAYING: begin
          if (startOfFrame) begin
            if (borderL) begin
              state      <= GAME_OVER;
              freezeGame <= 1'b1;
            end else begin
              score <= scoreSat;
              if (alienL) aliensRemaining <= aliensAfter;
              if (playerL) begin
                playerDiedPulse <= 1'b1;
                freezeGame      <= 1'b1;
                if (lives == 3'd1) begin
                  lives <= 3'd0;
                  state <= GAME_OVER;
                end else begin
                  lives    <= lives - 3'd1;
                  frameCnt <= '0;
                  state    <= PLAYER_HIT;
                end
              end else if (alienL && aliensAfter == 6'd0) begin
                frameCnt   <= '0;
                freezeGame <= 1'b1;
                state      <= LEVEL_CLEAR;
              end
            end
          end
        end

        PLAYER_HIT: begin
          if (startOfFrame) begin
            if (frameCntInc == CNT_W'(HIT_FREEZE_FRAMES)) begin
              frameCnt <= '0;
              // The final kill may have landed in the same commit as the death.
              if (aliensRemaining == 6'd0) begin
                state <= LEVEL_CLEAR;
              end else begin
                state      <= PLAYING;
                freezeGame <= 1'b0;
              end
            end else begin
              frameCnt <= frameCntInc;
            end
          end
        end

        LEVEL_CLEAR: begin
          if (startOfFrame) begin
            if (frameCntInc == CNT_W'(LEVEL_PAUSE_FRAMES)) begin
              frameCnt        <= '0;
              level           <= (level == 4'd15) ? 4'd15 : level + 4'd1;
              aliensRemaining <= 6'(ALIEN_COUNT);
              levelStartPulse <= 1'b1;
              freezeGame      <= 1'b0;
              state           <= PLAYING;
            end else begin
              frameCnt <= frameCntInc;
            end
          end
        end

        default: begin
          state      <= IDLE;
          freezeGame <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_state_manager.sv
// Directed bench for game_state_manager: a vector table for the opening moves, then hand-written
// multi-frame sequences; a second small-parameter instance covers score and level saturation.
module tb_game_state_manager;

  logic clk = 1'b0;
  logic reset = 1'b0, reset2 = 1'b0;
  logic sof = 1'b0, start = 1'b0, alien = 1'b0, pHitA = 1'b0, pHitR = 1'b0;
  logic rocket = 1'b0, border = 1'b0;

  logic [2:0]  gameState, lives, gameState2, lives2;
  logic [15:0] score;
  logic [6:0]  score2;
  logic [3:0]  level, level2;
  logic [5:0]  aliensRemaining, aliensRemaining2;
  logic        freezeGame, playerDiedPulse, levelStartPulse;
  logic        freezeGame2, playerDiedPulse2, levelStartPulse2;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  game_state_manager dut (
    .clk(clk), .reset(reset), .startOfFrame(sof), .startGame(start),
    .alienHitPulse(alien), .playerHitByAlienPulse(pHitA),
    .playerHitByRocketPulse(pHitR), .rocketsCollisionPulse(rocket),
    .aliensReachedBorder(border), .gameState(gameState), .score(score),
    .lives(lives), .level(level), .aliensRemaining(aliensRemaining),
    .freezeGame(freezeGame), .playerDiedPulse(playerDiedPulse),
    .levelStartPulse(levelStartPulse)
  );

  game_state_manager #(
    .LIVES_INIT(1), .ALIEN_COUNT(1), .HIT_FREEZE_FRAMES(2),
    .LEVEL_PAUSE_FRAMES(2), .SCORE_W(7)
  ) dut2 (
    .clk(clk), .reset(reset2), .startOfFrame(sof), .startGame(start),
    .alienHitPulse(alien), .playerHitByAlienPulse(pHitA),
    .playerHitByRocketPulse(pHitR), .rocketsCollisionPulse(rocket),
    .aliensReachedBorder(border), .gameState(gameState2), .score(score2),
    .lives(lives2), .level(level2), .aliensRemaining(aliensRemaining2),
    .freezeGame(freezeGame2), .playerDiedPulse(playerDiedPulse2),
    .levelStartPulse(levelStartPulse2)
  );

  typedef struct {
    logic rst, s, st, a, pr;
    logic [2:0]  expState;
    logic [15:0] expScore;
    logic [2:0]  expLives;
    logic [3:0]  expLevel;
    logic [5:0]  expAliens;
    logic        expDied, expLs;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic cyc(input logic s, input logic st, input logic a, input logic pa,
                     input logic pr, input logic r, input logic b);
    sof = s; start = st; alien = a; pHitA = pa; pHitR = pr; rocket = r; border = b;
    @(posedge clk);
    #1;
    sof = 0; start = 0; alien = 0; pHitA = 0; pHitR = 0; rocket = 0; border = 0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic kill();
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic die();
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  vec_t vecs[10];

  initial begin
    //          rst s  st a  pr  state score lives lvl aliens died ls
    vecs[0] = '{1, 0, 0, 0, 0, 3'd0,  16'd0, 3'd3, 4'd1, 6'd24, 0, 0};
    vecs[1] = '{0, 0, 1, 0, 0, 3'd1,  16'd0, 3'd3, 4'd1, 6'd24, 0, 1};
    vecs[2] = '{0, 0, 1, 0, 0, 3'd1,  16'd0, 3'd3, 4'd1, 6'd24, 0, 0};
    vecs[3] = '{0, 0, 0, 1, 0, 3'd1,  16'd0, 3'd3, 4'd1, 6'd24, 0, 0};
    vecs[4] = '{0, 1, 0, 0, 0, 3'd1, 16'd10, 3'd3, 4'd1, 6'd23, 0, 0};
    vecs[5] = '{0, 1, 0, 1, 0, 3'd1, 16'd10, 3'd3, 4'd1, 6'd23, 0, 0};
    vecs[6] = '{0, 1, 0, 0, 0, 3'd1, 16'd20, 3'd3, 4'd1, 6'd22, 0, 0};
    vecs[7] = '{0, 0, 0, 1, 1, 3'd1, 16'd20, 3'd3, 4'd1, 6'd22, 0, 0};
    vecs[8] = '{0, 1, 0, 0, 0, 3'd2, 16'd30, 3'd2, 4'd1, 6'd21, 1, 0};
    vecs[9] = '{0, 0, 0, 0, 0, 3'd2, 16'd30, 3'd2, 4'd1, 6'd21, 0, 0};

    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      reset = vecs[i].rst;
      cyc(vecs[i].s, vecs[i].st, vecs[i].a, 0, vecs[i].pr, 0, 0);
      reset = 0;
      check($sformatf("v%0d.state", i),  gameState,       vecs[i].expState);
      check($sformatf("v%0d.score", i),  score,           vecs[i].expScore);
      check($sformatf("v%0d.lives", i),  lives,           vecs[i].expLives);
      check($sformatf("v%0d.level", i),  level,           vecs[i].expLevel);
      check($sformatf("v%0d.aliens", i), aliensRemaining, vecs[i].expAliens);
      check($sformatf("v%0d.freeze", i), freezeGame,      (vecs[i].expState != 3'd1) ? 1 : 0);
      check($sformatf("v%0d.died", i),   playerDiedPulse, vecs[i].expDied);
      check($sformatf("v%0d.lstart", i), levelStartPulse, vecs[i].expLs);
    end

    // Freeze after the death; a kill during the freeze must never be committed.
    frames(10);
    cyc(0, 0, 1, 0, 0, 0, 0);
    frames(49);
    check("hit.stillFrozen", gameState, 2);
    frames(1);
    check("hit.resume", gameState, 1);
    check("hit.resumeFreeze", freezeGame, 0);
    frames(1);
    check("hit.killDiscarded", aliensRemaining, 21);

    // Many pulses in one frame count as one event.
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("multi.score", score, 40);
    check("multi.aliens", aliensRemaining, 20);

    cyc(0, 1, 0, 0, 0, 0, 0);
    check("playStart.noPulse", levelStartPulse, 0);
    check("playStart.score", score, 40);

    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("rocket.score", score, 45);

    for (int i = 0; i < 19; i++) kill();
    check("clear.preState", gameState, 1);
    check("clear.preAliens", aliensRemaining, 1);
    kill();
    check("clear.state", gameState, 3);
    check("clear.score", score, 245);
    check("clear.aliens", aliensRemaining, 0);
    check("clear.freeze", freezeGame, 1);
    frames(89);
    check("pause.stillClear", gameState, 3);
    check("pause.level", level, 1);
    frames(1);
    check("lvl2.state", gameState, 1);
    check("lvl2.level", level, 2);
    check("lvl2.aliens", aliensRemaining, 24);
    check("lvl2.pulse", levelStartPulse, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("lvl2.pulseOff", levelStartPulse, 0);

    // Border beats a simultaneous kill and blocks scoring.
    cyc(0, 0, 1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("border.state", gameState, 4);
    check("border.score", score, 245);
    check("border.lives", lives, 2);

    cyc(0, 1, 0, 0, 0, 0, 0);
    check("restart1.state", gameState, 1);
    check("restart1.score", score, 0);
    check("restart1.lives", lives, 3);
    check("restart1.level", level, 1);
    check("restart1.pulse", levelStartPulse, 1);

    die();
    check("death1.lives", lives, 2);
    check("death1.state", gameState, 2);
    frames(60);
    die();
    check("death2.lives", lives, 1);
    frames(60);
    kill();
    check("preDeath3.score", score, 10);
    die();
    check("death3.lives", lives, 0);
    check("death3.state", gameState, 4);
    check("death3.died", playerDiedPulse, 1);
    cyc(0, 1, 0, 0, 0, 0, 0);
    check("restart2.state", gameState, 1);
    check("restart2.score", score, 0);
    check("restart2.lives", lives, 3);

    // Reset in the middle of a freeze.
    kill();
    die();
    frames(5);
    check("midReset.preState", gameState, 2);
    reset = 1;
    cyc(0, 0, 0, 1, 0, 0, 0);
    reset = 0;
    check("midReset.state", gameState, 0);
    check("midReset.score", score, 0);
    check("midReset.lives", lives, 3);
    check("midReset.aliens", aliensRemaining, 24);
    check("midReset.freeze", freezeGame, 1);
    frames(1);
    check("midReset.idleHolds", gameState, 0);

    // Small instance: one alien per level, 7-bit score, short pauses.
    reset2 = 1;
    cyc(0, 0, 0, 0, 0, 0, 0);
    reset2 = 0;
    cyc(0, 1, 0, 0, 0, 0, 0);
    check("sat.startState", gameState2, 1);
    check("sat.startAliens", aliensRemaining2, 1);
    for (int k = 1; k <= 16; k++) begin
      kill();
      frames(2);
      check($sformatf("sat%0d.score", k), score2, (10 * k > 127) ? 127 : 10 * k);
      check($sformatf("sat%0d.level", k), level2, (1 + k > 15) ? 15 : 1 + k);
      check($sformatf("sat%0d.state", k), gameState2, 1);
    end
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("sat.rocket", score2, 127);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
